// File: rtl/core_ex_port_pkg.sv
// Shared types for the core-side exclusive access port.
package core_ex_port_pkg;

    typedef logic [31:0] word;
    typedef logic [29:0] word_addr;
    typedef logic [27:0] line_addr;

    typedef enum logic [1:0] {
        AVL_OKAY   = 2'b00,
        AVL_SLVERR = 2'b10
    } avl_resp;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_READ,
        PORT_WRITE,
        PORT_DONE
    } port_state;

    // Reservation granule: the word address with its in-line offset dropped.
    function automatic line_addr line_of(input word_addr addr);
        return addr[29:2];
    endfunction

endpackage

// File: rtl/core_ex_port_if.sv
// Avalon-MM link between a core port (master) and its cache (slave).
interface core_ex_port_if;
    import core_ex_port_pkg::*;

    word_addr   address;
    logic       read;
    logic       write;
    logic       lock;
    word        writedata;
    logic       waitrequest;
    word        readdata;
    logic [1:0] response;

    modport master (
        output address, read, write, lock, writedata,
        input  waitrequest, readdata, response
    );

    modport slave (
        input  address, read, write, lock, writedata,
        output waitrequest, readdata, response
    );

endinterface

// File: rtl/core_ex_reservation.sv
// Local exclusive reservation: one line, set by ldrex, cleared by strex/clrex.
module core_ex_reservation
    import core_ex_port_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set,
    input  logic     clr,
    input  logic     clrex,
    input  line_addr line_in,
    output logic     match
);

    logic     valid;
    line_addr line;

    // Reservation register; clrex overrides any same-cycle set or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            line  <= '0;
        end else if (clrex || clr) begin
            valid <= 1'b0;
        end else if (set) begin
            valid <= 1'b1;
            line  <= line_in;
        end
    end

    // A clrex arriving with the strex must make that strex fail locally.
    assign match = valid && !clrex && (line == line_in);

endmodule

// File: rtl/core_ex_port.sv
// Core-side initiator for plain and exclusive word accesses to the cache port.
module core_ex_port
    import core_ex_port_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     core_start,
    input  logic     core_write,
    input  logic     core_ex,
    input  logic     core_clrex,
    input  word_addr core_address,
    input  word      core_writedata,
    output logic     core_busy,
    output logic     core_ready,
    output word      core_readdata,
    output logic     core_ex_fail,
    core_ex_port_if.master avl
);

    port_state state;
    logic      accept;
    logic      res_set;
    logic      res_clr;
    logic      res_match;

    assign accept  = (state == PORT_IDLE) && core_start;
    assign res_set = accept && !core_write && core_ex;
    assign res_clr = accept && core_write && core_ex;

    core_ex_reservation u_res (
        .clk     (clk),
        .rst     (rst),
        .set     (res_set),
        .clr     (res_clr),
        .clrex   (core_clrex),
        .line_in (line_of(core_address)),
        .match   (res_match)
    );

    // Request sequencing; bus and core outputs are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PORT_IDLE;
            avl.address   <= '0;
            avl.read      <= 1'b0;
            avl.write     <= 1'b0;
            avl.lock      <= 1'b0;
            avl.writedata <= '0;
            core_busy     <= 1'b0;
            core_ready    <= 1'b0;
            core_readdata <= '0;
            core_ex_fail  <= 1'b0;
        end else begin
            core_ready <= 1'b0;
            unique case (state)
                PORT_IDLE: begin
                    if (core_start) begin
                        core_busy    <= 1'b1;
                        core_ex_fail <= 1'b0;
                        if (!core_write) begin
                            avl.address <= core_address;
                            avl.read    <= 1'b1;
                            avl.lock    <= core_ex;
                            state       <= PORT_READ;
                        end else if (!core_ex || res_match) begin
                            avl.address   <= core_address;
                            avl.write     <= 1'b1;
                            avl.writedata <= core_writedata;
                            avl.lock      <= core_ex;
                            state         <= PORT_WRITE;
                        end else begin
                            core_ex_fail <= 1'b1;
                            core_ready   <= 1'b1;
                            state        <= PORT_DONE;
                        end
                    end
                end
                PORT_READ: begin
                    if (!avl.waitrequest) begin
                        avl.read      <= 1'b0;
                        avl.lock      <= 1'b0;
                        core_readdata <= avl.readdata;
                        core_ready    <= 1'b1;
                        state         <= PORT_DONE;
                    end
                end
                PORT_WRITE: begin
                    if (!avl.waitrequest) begin
                        avl.write    <= 1'b0;
                        avl.lock     <= 1'b0;
                        core_ex_fail <= avl.lock && ((avl.response & AVL_SLVERR) != '0);
                        core_ready   <= 1'b1;
                        state        <= PORT_DONE;
                    end
                end
                PORT_DONE: begin
                    core_busy <= 1'b0;
                    state     <= PORT_IDLE;
                end
                default: state <= PORT_IDLE;
            endcase
        end
    end

endmodule

// File: doc/core_ex_port.md
# core_ex_port

Core-side initiator for exclusive (ldrex/strex) and plain word accesses toward the per-core cache port. It accepts one request at a time from the core pipeline, keeps a local exclusive reservation, drives the Avalon-MM port with `lock` marking exclusive accesses, and decodes the cache's `response` into the strex status word. It sits between each core's memory stage and its cache, mirroring the cache-side exclusive monitor.

## Interface
- No parameters. Widths come from `cache/defs.sv` (`word` = 32 bits, word address = 30 bits = {`addr_tag`, `addr_index`, `addr_offset`}).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_start` in 1: request strobe; sampled only in IDLE.
- `core_write` in 1: 1 = store/strex, 0 = load/ldrex.
- `core_ex` in 1: exclusive access (ldrex/strex).
- `core_clrex` in 1: clear local reservation (clrex, exception entry).
- `core_address` in 30: word address.
- `core_writedata` in 32: store data.
- `core_busy` out 1: high whenever not IDLE.
- `core_ready` out 1: one-cycle completion pulse.
- `core_readdata` out 32: load result, valid with `core_ready`, held until next completion.
- `core_ex_fail` out 1: strex status (0 = stored, 1 = failed), valid with `core_ready`; 0 for other ops.
- `avl_address` out 30; `avl_read` out 1; `avl_write` out 1; `avl_lock` out 1; `avl_writedata` out 32.
- `avl_waitrequest` in 1; `avl_readdata` in 32; `avl_response` in 2 (00 OKAY, 10 SLVERR).

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + `core_start`: latch address/data/write/ex. Load → READ. Store without ex → WRITE. strex: if reservation valid and `res_line == core_address[29:2]` → WRITE with lock; else → DONE with `core_ex_fail`=1, no bus cycle.
- ldrex: on accept, set `res_valid`=1, `res_line`=`core_address[29:2]`; READ with `avl_lock`=1.
- READ/WRITE: hold `avl_read`/`avl_write`, address, data, lock constant until `avl_waitrequest`=0; that cycle capture `avl_readdata` (READ) or `avl_response[1]` as fail (locked WRITE only), → DONE.
- DONE: `core_ready`=1 one cycle → IDLE.
- Every strex (local fail or bus) clears `res_valid` at accept.
- `core_clrex` clears `res_valid` in any state; clrex and strex-accept in the same cycle: clrex wins, strex fails locally.
- `core_start` while not IDLE is ignored.
- Plain stores/loads do not touch the reservation.
- `avl_response` on non-locked transfers ignored.

## Timing
- Reset: state IDLE, `res_valid`=0, all `avl_*` outputs 0, `core_busy`=0, `core_ready`=0, `core_readdata`=0, `core_ex_fail`=0.
- Accept at edge k; bus request visible cycle k+1; grant (`waitrequest`=0) in cycle g ≥ k+1; `core_ready` in cycle g+1. Zero-wait minimum latency: 2 cycles start→ready.
- strex local fail: `core_ready` in cycle k+1.
- `rst` mid-transfer drops `avl_read`/`avl_write` next edge; no completion pulse.
- Back-to-back: new `core_start` accepted in the cycle after `core_ready` (IDLE).

## Structure
- Add to `cache/defs.sv`: `avl_resp` enum (OKAY=2'b00, SLVERR=2'b10), `line_addr` typedef ({tag,index}, 28 bits), port state enum.
- Sub-module `core_ex_reservation`: `res_valid`/`res_line` register with set, clear, clrex-priority and match output. FSM and datapath in `core_ex_port`.

## Test plan
- ldrex 0x100 with 2 wait cycles, readdata 0xDEADBEEF → `avl_lock`=1 during read, `core_ready` 3 cycles after grant start, `core_readdata`=0xDEADBEEF, reservation line 0x40.
- ldrex 0x100 then strex 0x101, response 00 → locked write issued, `core_ex_fail`=0; second strex 0x101 → no bus cycle, `core_ex_fail`=1 at k+1.
- ldrex 0x100, strex 0x100 with response 10 → `core_ex_fail`=1, reservation cleared.
- ldrex 0x100, then `core_clrex` same cycle as strex 0x100 → no bus write, fail=1.
- strex 0x200 after ldrex 0x100 → local fail; plain store 0x200 → `avl_lock`=0, fail=0.
- `rst` asserted while `avl_write` pending → next cycle all outputs 0, state IDLE, no `core_ready`.
